// File: rtl/cnn_layer_seq.sv
// CNN core scheduler: unpacks UART image bytes into the 1-bit input RAM, walks the
// layer chain with one-hot start/done handshakes, then ships the predicted label.
module cnn_layer_seq #(
  parameter int IMG_BYTES   = 98,
  parameter int NUM_LAYERS  = 5,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_rdy,
  input  logic [7:0]            rx_data,
  output logic                  in_we,
  output logic [ADDR_W-1:0]     in_waddr,
  output logic                  in_wdata,
  output logic [NUM_LAYERS-1:0] lyr_start,
  input  logic [NUM_LAYERS-1:0] lyr_done,
  input  logic [3:0]            pred,
  output logic                  trmt,
  output logic [7:0]            tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  err_ovr,
  output logic                  err_tmo
);

  localparam int LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SER     = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_SEND    = 3'd5;
  localparam logic [2:0] S_WAIT_TX = 3'd6;

  logic [2:0]        r_state;
  logic [7:0]        r_shreg;
  logic [6:0]        r_byte_cnt;
  logic [2:0]        r_bit_cnt;
  logic [LIDX_W-1:0] r_lyr_idx;
  logic [WDOG_W-1:0] r_wdog;
  logic [7:0]        r_tx_data;
  logic              r_err_ovr;
  logic              r_err_tmo;

  logic w_accept;
  logic w_ser;
  logic w_last_lyr;

  // Bytes are only taken while waiting for one; anything else is an overrun.
  assign w_accept   = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_ser      = (r_state == S_SER);
  assign w_last_lyr = (r_lyr_idx == LIDX_W'(NUM_LAYERS - 1));

  assign in_we     = w_ser;
  assign in_waddr  = ADDR_W'({r_byte_cnt, r_bit_cnt});
  assign in_wdata  = w_ser & r_shreg[r_bit_cnt];
  assign lyr_start = (r_state == S_START) ? (NUM_LAYERS'(1) << r_lyr_idx) : '0;
  assign trmt      = (r_state == S_SEND);
  assign tx_data   = r_tx_data;
  assign busy      = (r_state != S_IDLE);
  assign err_ovr   = r_err_ovr;
  assign err_tmo   = r_err_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_lyr_idx  <= '0;
      r_wdog     <= '0;
      r_tx_data  <= '0;
      r_err_ovr  <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      if (rx_rdy && !w_accept) r_err_ovr <= 1'b1;
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (rx_rdy) begin
            r_shreg   <= rx_data;
            r_bit_cnt <= '0;
            r_state   <= S_SER;
          end
        end
        S_SER: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_byte_cnt == 7'(IMG_BYTES - 1)) begin
              r_byte_cnt <= 7'(IMG_BYTES);
              r_lyr_idx  <= '0;
              r_state    <= S_START;
            end else begin
              r_byte_cnt <= r_byte_cnt + 7'd1;
              r_state    <= S_LOAD;
            end
          end
        end
        S_START: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Only the running layer's done counts; the watchdog yields to a same-cycle done.
          if (lyr_done[r_lyr_idx]) begin
            if (w_last_lyr) begin
              r_tx_data <= {4'h0, pred};
              r_state   <= S_SEND;
            end else begin
              r_lyr_idx <= r_lyr_idx + LIDX_W'(1);
              r_state   <= S_START;
            end
          end else if (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
            r_err_tmo  <= 1'b1;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_lyr_idx  <= '0;
            r_wdog     <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        S_SEND: r_state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (tx_done) begin
            r_byte_cnt <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for cnn_layer_seq: image load, layer chain, transmit, overrun, watchdog, reset.
module tb_cnn_layer_seq;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       in_we;
  logic [9:0] in_waddr;
  logic       in_wdata;
  logic [4:0] lyr_start;
  logic [4:0] lyr_done = '0;
  logic [3:0] pred = '0;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       busy, err_ovr, err_tmo;

  cnn_layer_seq #(.IMG_BYTES(98), .NUM_LAYERS(5), .ADDR_W(10), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .lyr_start(lyr_start), .lyr_done(lyr_done), .pred(pred),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .err_ovr(err_ovr), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] addr; logic bitv; } wr_vec_t;
  typedef struct { logic [4:0] exp_start; } lyr_vec_t;

  wr_vec_t  wv[8];
  lyr_vec_t lv[5];

  int errs = 0;
  int checks = 0;

  logic mem [784];
  int wr_cnt = 0;
  int first_addr = -1;
  int last_addr = -1;
  int start_cnt = 0;

  always @(negedge clk) begin
    if (in_we === 1'b1) begin
      if (wr_cnt == 0) first_addr = int'(in_waddr);
      if (in_waddr < 10'd784) mem[in_waddr] = in_wdata;
      last_addr = int'(in_waddr);
      wr_cnt++;
    end
    if (lyr_start !== 5'd0) start_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] img_byte(input int s, input int i);
    int v;
    if (s == 0 && i == 0) return 8'hA5;
    v = i * 37 + s * 91 + 11;
    return v[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_rdy = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  // Sends nbytes of image set s, 11 cycles apart; optional overrun after byte ovr_at.
  task automatic load_image(input int s, input int nbytes, input int ovr_at);
    for (int a = 0; a < 784; a++) mem[a] = 1'bx;
    wr_cnt = 0;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(img_byte(s, i));
      if (i == 97) begin
        chk("last_byte_we_first", 32'(in_we), 32'd1);
        repeat (7) @(negedge clk);
        chk("last_write_addr", 32'(in_waddr), 32'd783);
        @(negedge clk);
        chk("start0_after_load", 32'(lyr_start), 32'b00001);
        chk("we_off_after_load", 32'(in_we), 32'd0);
      end else if (i == ovr_at) begin
        chk("ovr_clear_before", 32'(err_ovr), 32'd0);
        repeat (2) @(negedge clk);
        rx_rdy = 1'b1;
        rx_data = 8'hFF;
        @(negedge clk);
        rx_rdy = 1'b0;
        chk("ovr_set", 32'(err_ovr), 32'd1);
        repeat (6) @(negedge clk);
      end else begin
        repeat (9) @(negedge clk);
      end
    end
  endtask

  task automatic check_image(input int s);
    logic [7:0] b;
    int bad;
    bad = 0;
    for (int i = 0; i < 98; i++) begin
      for (int k = 0; k < 8; k++) b[k] = mem[i*8 + k];
      if (b !== img_byte(s, i) && bad == 0) begin
        bad = 1;
        $display("FAIL image_byte[%0d]: got %0h expected %0h", i, b, img_byte(s, i));
      end
    end
    checks++;
    if (bad != 0) errs++;
    chk("write_count", 32'(wr_cnt), 32'd784);
    chk("first_addr", 32'(first_addr), 32'd0);
    chk("last_addr", 32'(last_addr), 32'd783);
  endtask

  // Entered on the negedge where lyr_start[0] is visible. stop_at<5 returns at that layer's start.
  task automatic run_layers(input logic [3:0] p, input int stop_at);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lyr_start_%0d", k), 32'(lyr_start), 32'(lv[k].exp_start));
      if (k == stop_at) return;
      if (k == 0) lyr_done = 5'b00001;
      for (int e = 1; e <= 50; e++) begin
        @(negedge clk);
        lyr_done = '0;
        if (k == 0 && e == 1) chk("same_cycle_done_ignored", 32'(lyr_start), 32'd0);
        if (k == 1 && e == 10) lyr_done = 5'b01000;
        if (k == 1 && e == 11) chk("foreign_done_ignored", 32'(lyr_start), 32'd0);
      end
      pred = p;
      lyr_done = 5'(1 << k);
      @(negedge clk);
      lyr_done = '0;
    end
    chk("trmt_pulse", 32'(trmt), 32'd1);
    chk("tx_data", 32'(tx_data), 32'({4'h0, p}));
    @(negedge clk);
    pred = 4'hF;
    chk("trmt_one_cycle", 32'(trmt), 32'd0);
    repeat (5) @(negedge clk);
    chk("busy_in_wait_tx", 32'(busy), 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("idle_after_tx_done", 32'(busy), 32'd0);
    chk("tx_data_hold", 32'(tx_data), 32'({4'h0, p}));
  endtask

  initial begin
    int snap;
    wv[0] = '{10'd0, 1'b1}; wv[1] = '{10'd1, 1'b0}; wv[2] = '{10'd2, 1'b1}; wv[3] = '{10'd3, 1'b0};
    wv[4] = '{10'd4, 1'b0}; wv[5] = '{10'd5, 1'b1}; wv[6] = '{10'd6, 1'b0}; wv[7] = '{10'd7, 1'b1};
    lv[0] = '{5'b00001}; lv[1] = '{5'b00010}; lv[2] = '{5'b00100};
    lv[3] = '{5'b01000}; lv[4] = '{5'b10000};

    repeat (3) @(negedge clk);
    chk("rst_in_we", 32'(in_we), 32'd0);
    chk("rst_in_waddr", 32'(in_waddr), 32'd0);
    chk("rst_in_wdata", 32'(in_wdata), 32'd0);
    chk("rst_lyr_start", 32'(lyr_start), 32'd0);
    chk("rst_trmt", 32'(trmt), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'({err_ovr, err_tmo}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Image 1, full layer chain, transmit label 5
    load_image(0, 98, -1);
    for (int v = 0; v < 8; v++)
      chk($sformatf("first_byte_bit%0d", v), 32'(mem[wv[v].addr]), 32'(wv[v].bitv));
    check_image(0);
    run_layers(4'h5, 5);

    // Image 2 with a dropped mid-SER byte, label A
    load_image(1, 98, 20);
    check_image(1);
    run_layers(4'hA, 5);
    chk("ovr_sticky", 32'(err_ovr), 32'd1);

    // Image 3: withhold layer 2 done, expect watchdog abort
    load_image(2, 98, -1);
    run_layers(4'h3, 2);
    repeat (98) @(negedge clk);
    chk("tmo_not_yet", 32'(err_tmo), 32'd0);
    chk("busy_before_tmo", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    chk("tmo_set", 32'(err_tmo), 32'd1);
    chk("idle_after_tmo", 32'(busy), 32'd0);
    snap = start_cnt;
    repeat (30) @(negedge clk);
    chk("no_start_after_tmo", 32'(start_cnt), 32'(snap));

    // Reset during byte 40's serialisation, then a fresh load from address 0
    load_image(3, 40, -1);
    send_byte(img_byte(3, 40));
    @(negedge clk);
    chk("we_before_rst", 32'(in_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("we_off_on_rst", 32'(in_we), 32'd0);
    chk("busy_off_on_rst", 32'(busy), 32'd0);
    chk("err_clear_on_rst", 32'({err_ovr, err_tmo}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_start_after_rst", 32'(lyr_start), 32'd0);
    load_image(4, 98, -1);
    check_image(4);
    run_layers(4'h7, 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
